// File: rtl/poly_note_pkg.sv
// Shared types and pitch arithmetic for the polyphonic note player.
// Half-periods derive from octave-0 note frequencies in millihertz.
package poly_note_pkg;

  typedef enum logic {V_IDLE, V_RUN} voice_state_t;

  localparam int NOTE_REST = 12;

  localparam int unsigned NOTE_MHZ [12] = '{
    16352, 17324, 18354, 19445, 20602, 21827,
    23125, 24500, 25957, 27500, 29135, 30868
  };

  // Clock cycles per half-period, never below 1.
  function automatic longint unsigned half_period(longint unsigned clk_hz,
                                                  int unsigned note,
                                                  int unsigned oct);
    longint unsigned h;
    h = ((clk_hz * 64'd1000) / (64'd2 * 64'(NOTE_MHZ[note]))) >> oct;
    if (h == 64'd0) h = 64'd1;
    return h;
  endfunction

endpackage

// File: rtl/note_voice.sv
// One square-wave voice: half-period down-counter, pending pitch register and
// IDLE/RUN state machine. Pitch and rest changes land only at a boundary.
module note_voice
  import poly_note_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             wr_rest,
  input  logic [CNT_W-1:0] wr_half,
  output logic             out,
  output voice_state_t     state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  voice_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] pend_half_q;
  logic             pend_rest_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= V_IDLE;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      pend_half_q <= '0;
      pend_rest_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      // Last write wins; a boundary in this same cycle still sees the old pend.
      if (wr) begin
        pend_half_q <= wr_half;
        pend_rest_q <= wr_rest;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      V_IDLE: begin
        if (wr && !wr_rest) begin
          state_d = V_RUN;
          cnt_d   = wr_half - ONE;
          out_d   = 1'b1;
        end
      end
      V_RUN: begin
        if (cnt_q == '0) begin
          if (pend_rest_q) begin
            state_d = V_IDLE;
            out_d   = 1'b0;
          end else begin
            out_d = ~out_q;
            cnt_d = pend_half_q - ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = V_IDLE;
    endcase
  end

  assign out   = out_q;
  assign state = state_q;

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic square-wave player: write decode, VOICES note_voice instances,
// registered popcount mix and a 1-bit speaker stage. Defining POLY_PDM_EN makes
// the speaker a sigma-delta of mix; otherwise it is the XOR (parity) of voices.
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter  int CLK_HZ = 50000000,
  parameter  int VOICES = 4,
  parameter  int CNT_W  = 21,
  localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int MW     = $clog2(VOICES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [VW-1:0]     wr_voice,
  input  logic [3:0]        wr_note,
  input  logic [2:0]        wr_oct,
  output logic [VOICES-1:0] voice_out,
  output logic [VOICES-1:0] active,
  output logic [MW-1:0]     mix,
  output logic              speaker
);

  // Octave-0 half-periods are elaboration constants; only the shift is live.
  logic [CNT_W-1:0] half_tab [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_tab
    if (gi < NOTE_REST) begin : g_note
      assign half_tab[gi] = CNT_W'(half_period(64'(CLK_HZ), gi, 0));
    end else begin : g_rest
      assign half_tab[gi] = '0;
    end
  end

  logic             wr_ok;
  logic             wr_rest;
  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] wr_half;

  always_comb begin
    wr_rest = (wr_note >= 4'(NOTE_REST));
    shifted = half_tab[wr_note] >> wr_oct;
    wr_half = (shifted == '0) ? CNT_W'(1) : shifted;
    wr_ok   = wr_en && (32'(wr_voice) < 32'(VOICES));
  end

  voice_state_t vstate [VOICES];

  for (genvar gv = 0; gv < VOICES; gv++) begin : g_voice
    note_voice #(.CNT_W(CNT_W)) u_voice (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_ok && (32'(wr_voice) == gv)),
      .wr_rest (wr_rest),
      .wr_half (wr_half),
      .out     (voice_out[gv]),
      .state   (vstate[gv])
    );
    assign active[gv] = (vstate[gv] == V_RUN);
  end

  logic [MW-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < VOICES; i++) pop = pop + MW'(voice_out[i]);
  end

`ifdef POLY_PDM_EN
  localparam int AW = $clog2(2 * VOICES + 1);
  logic [AW-1:0] acc_q;
  logic [AW-1:0] sum;

  assign sum = acc_q + AW'(mix);

  always_ff @(posedge clk) begin
    if (reset) begin
      mix     <= '0;
      speaker <= 1'b0;
      acc_q   <= '0;
    end else begin
      mix <= pop;
      if (sum >= AW'(VOICES)) begin
        speaker <= 1'b1;
        acc_q   <= sum - AW'(VOICES);
      end else begin
        speaker <= 1'b0;
        acc_q   <= sum;
      end
    end
  end
`else
  // Parity of the registered popcount is the XOR of the voices one cycle back.
  always_ff @(posedge clk) begin
    if (reset) begin
      mix     <= '0;
      speaker <= 1'b0;
    end else begin
      mix     <= pop;
      speaker <= mix[0];
    end
  end
`endif

endmodule
